imem_boot_loader: RTL and testbench

- Writer side of the instruction memory. Fills instruction memory from a byte stream, the synthesizable counterpart of the simulation-only text-dump preload in PipeSystem.
- Sits between an external byte source (UART receiver / host bridge) and the instruction memory write port.
- Holds the pipelined CPU stalled until the image is written and its checksum verified, then releases it to fetch from word address 0.

---
 rtl/imem_boot_loader_pkg.sv | 25 ++
 rtl/imem_boot_loader_if.sv | 34 +++
 rtl/imem_boot_loader_byte_word_packer.sv | 34 +++
 rtl/imem_boot_loader.sv | 127 ++++++++++++
 tb/tb_imem_boot_loader.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared widths and state encoding for the
// instruction-memory boot loader and its byte packer.
package imem_boot_loader_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;
   localparam int LEN_W  = 16;

   typedef logic [BYTE_W-1:0] byte_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   function automatic logic accepts(state_t s);
      return (s != S_DONE) && (s != S_ERROR);
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream input handshake plus the
// instruction-memory write port driven by the loader.
interface imem_boot_loader_if
   import imem_boot_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
);

   logic                  in_valid;
   byte_t                 in_data;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   word_t                 imem_wdata;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );

endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// byte_word_packer: big-endian 4-byte assembler with a one-cycle
// word_valid pulse following the fourth byte.
module byte_word_packer
   import imem_boot_loader_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       in_en,
   input  byte_t      in_byte,
   output word_t      word,
   output logic       word_valid,
   output logic [1:0] byte_idx
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         word       <= '0;
         byte_idx   <= '0;
         word_valid <= 1'b0;
      end else if (clear) begin
         word       <= '0;
         byte_idx   <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= in_en && (byte_idx == 2'd3);
         if (in_en) begin
            word     <= {word[WORD_W-BYTE_W-1:0], in_byte};
            byte_idx <= byte_idx + 2'd1;
         end
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed, XOR-checked image
// into instruction memory and holds the CPU until it verifies.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   imem_boot_loader_if.slave bus,
   input  logic              start,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam logic [LEN_W:0] ONE     = 1;
   localparam logic [LEN_W:0] MAX_LEN = ONE << ADDR_WIDTH;

   state_t                state;
   state_t                state_nx;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      len_full;
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [LEN_W:0]        wc_ext;
   byte_t                 chk;
   logic                  xfer;
   logic                  restart;
   logic                  last_word;
   logic                  pk_en;
   logic                  word_valid;
   logic [1:0]            byte_idx;
   logic [DATA_WIDTH-1:0] word;

   assign xfer     = bus.in_valid && bus.in_ready;
   assign restart  = start && !accepts(state);
   assign len_full = {len_q[LEN_W-1:BYTE_W], bus.in_data};
   assign pk_en    = xfer && (state == S_DATA);

   // One extra counter bit lets a full 2^ADDR_WIDTH image finish
   always_comb begin
      wc_ext = '0;
      wc_ext[ADDR_WIDTH:0] = word_cnt;
   end

   assign last_word = (wc_ext + ONE) == {1'b0, len_q};

   byte_word_packer u_packer (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (restart),
      .in_en      (pk_en),
      .in_byte    (bus.in_data),
      .word       (word),
      .word_valid (word_valid),
      .byte_idx   (byte_idx)
   );

   assign bus.in_ready   = accepts(state);
   assign bus.imem_we    = word_valid;
   assign bus.imem_addr  = word_cnt[ADDR_WIDTH-1:0];
   assign bus.imem_wdata = word;
   assign done           = (state == S_DONE);
   assign error          = (state == S_ERROR);

   always_comb begin
      state_nx = state;
      unique case (state)
         S_LEN_HI: begin
            if (xfer) state_nx = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (xfer) begin
               if ({1'b0, len_full} > MAX_LEN)
                  state_nx = S_ERROR;
               else if (len_full == '0)
                  state_nx = S_CHECK;
               else
                  state_nx = S_DATA;
            end
         end
         S_DATA: begin
            if (pk_en && byte_idx == 2'd3 && last_word)
               state_nx = S_CHECK;
         end
         S_CHECK: begin
            if (xfer)
               state_nx = (bus.in_data == chk) ? S_DONE
                                               : S_ERROR;
         end
         S_DONE, S_ERROR: begin
            if (start) state_nx = S_LEN_HI;
         end
         default: state_nx = S_LEN_HI;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_LEN_HI;
         len_q    <= '0;
         word_cnt <= '0;
         chk      <= '0;
         cpu_hold <= 1'b1;
      end else begin
         state    <= state_nx;
         // CPU is released one cycle after DONE is reached
         cpu_hold <= (state != S_DONE) || start;
         if (restart) begin
            len_q    <= '0;
            word_cnt <= '0;
            chk      <= '0;
         end else begin
            if (xfer && state == S_LEN_HI)
               len_q[LEN_W-1:BYTE_W] <= bus.in_data;
            if (xfer && state == S_LEN_LO)
               len_q[BYTE_W-1:0] <= bus.in_data;
            if (pk_en)
               chk <= chk ^ bus.in_data;
            if (word_valid)
               word_cnt <= word_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed and randomized frames checked
// against a frame-level reference model of the loader.
module tb_imem_boot_loader;
   import imem_boot_loader_pkg::*;

   localparam int AW = 10;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic cpu_hold, done, error;

   imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus();

   imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .bus      (bus),
      .start    (start),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [7:0]    frame[$];
   logic [AW-1:0] exp_a[$];
   logic [31:0]   exp_d[$];
   int            exp_res;
   logic [AW-1:0] got_a[$];
   logic [31:0]   got_d[$];

   always @(negedge clock)
      if (bus.imem_we) begin
         got_a.push_back(bus.imem_addr);
         got_d.push_back(bus.imem_wdata);
      end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: decode the frame with plain arithmetic.
   task automatic model_frame();
      int n;
      logic [7:0] c;
      exp_a.delete();
      exp_d.delete();
      c = 8'h00;
      n = (int'(frame[0]) << 8) | int'(frame[1]);
      if (n > (1 << AW)) begin
         exp_res = 2;
         return;
      end
      for (int i = 0; i < n; i++) begin
         exp_a.push_back(AW'(i));
         exp_d.push_back({frame[2+4*i], frame[3+4*i],
                          frame[4+4*i], frame[5+4*i]});
         for (int k = 0; k < 4; k++) c ^= frame[2+4*i+k];
      end
      exp_res = (frame[2+4*n] == c) ? 1 : 2;
   endtask

   task automatic make_frame(input int n, input bit bad);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h00;
      frame.delete();
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom);
         c ^= b;
         frame.push_back(b);
      end
      frame.push_back(bad ? ~c : c);
   endtask

   task automatic fixed_frame(input logic [7:0] chk);
      logic [7:0] f [10];
      f = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
            8'h00, 8'h00, 8'h00, 8'h00};
      frame.delete();
      foreach (f[i]) frame.push_back(f[i]);
      frame.push_back(chk);
   endtask

   // Called and returns at a negedge; back-to-back when gap == 0.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      while (gap > 0 && n < 8 && $urandom_range(99) < gap) begin
         bus.in_valid = 1'b0;
         @(negedge clock);
         n++;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready=0 for 20 cycles, need 1");
         bus.in_valid = 1'b0;
         return;
      end
      @(negedge clock);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_range(input int lo, input int hi,
                             input int gap);
      for (int i = lo; i < hi; i++) send_byte(frame[i], gap);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      checks++;
      if ({bus.in_ready, bus.imem_we, cpu_hold, done, error}
          !== 5'b10100) begin
         errors++;
         $display("FAIL reset_flags: rdy/we/hold/done/err=%b need 10100",
                  {bus.in_ready, bus.imem_we, cpu_hold, done, error});
      end
      checks++;
      if (bus.imem_addr !== '0 || bus.imem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_bus: addr=%h wdata=%h need 0/0",
                  bus.imem_addr, bus.imem_wdata);
      end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_good_frame();
      fixed_frame(8'h29);
      got_a.delete();
      got_d.delete();
      send_range(0, 1, 0);
      pulse_start();
      checks++;
      if (bus.in_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL start_ignored: rdy=%b done=%b need 1/0",
                  bus.in_ready, done);
      end
      send_range(1, 6, 0);
      checks++;
      if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd0 ||
          bus.imem_wdata !== 32'h24080005) begin
         errors++;
         $display("FAIL strobe0: we=%b addr=%h data=%h need 1/000/24080005",
                  bus.imem_we, bus.imem_addr, bus.imem_wdata);
      end
      send_range(6, 7, 0);
      checks++;
      if (bus.imem_we !== 1'b0) begin
         errors++;
         $display("FAIL strobe_width: we=%b need 0", bus.imem_we);
      end
      send_range(7, 11, 0);
      checks++;
      if ({done, error, cpu_hold, bus.in_ready} !== 4'b1010) begin
         errors++;
         $display("FAIL good_entry: done/err/hold/rdy=%b need 1010",
                  {done, error, cpu_hold, bus.in_ready});
      end
      @(negedge clock);
      checks++;
      if (cpu_hold !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL good_release: hold=%b done=%b need 0/1",
                  cpu_hold, done);
      end
      checks++;
      if (got_a.size() != 2) begin
         errors++;
         $display("FAIL good_count: writes=%0d need 2", got_a.size());
      end else begin
         checks++;
         if (got_a[0] !== 10'd0 || got_d[0] !== 32'h24080005 ||
             got_a[1] !== 10'd1 || got_d[1] !== 32'h00000000) begin
            errors++;
            $display("FAIL good_writes: %h:%h %h:%h need 000:24080005 001:00000000",
                     got_a[0], got_d[0], got_a[1], got_d[1]);
         end
      end
   endtask

   task automatic test_bad_checksum();
      pulse_start();
      checks++;
      if ({done, cpu_hold, bus.in_ready} !== 3'b011) begin
         errors++;
         $display("FAIL restart_done: done/hold/rdy=%b need 011",
                  {done, cpu_hold, bus.in_ready});
      end
      fixed_frame(8'h28);
      send_range(0, 11, 0);
      @(negedge clock);
      checks++;
      if ({error, done, cpu_hold, bus.in_ready} !== 4'b1010) begin
         errors++;
         $display("FAIL bad_chk: err/done/hold/rdy=%b need 1010",
                  {error, done, cpu_hold, bus.in_ready});
      end
      pulse_start();
      checks++;
      if ({error, cpu_hold, bus.in_ready} !== 3'b011) begin
         errors++;
         $display("FAIL restart_err: err/hold/rdy=%b need 011",
                  {error, cpu_hold, bus.in_ready});
      end
      fixed_frame(8'h29);
      got_a.delete();
      got_d.delete();
      send_range(0, 11, 0);
      checks++;
      if (done !== 1'b1 || got_a.size() != 2 || got_a[0] !== 10'd0) begin
         errors++;
         $display("FAIL after_err: done=%b writes=%0d need 1/2 from addr 0",
                  done, got_a.size());
      end
   endtask

   task automatic test_len_limits();
      pulse_start();
      got_a.delete();
      frame = '{8'h04, 8'h01};
      send_range(0, 2, 0);
      checks++;
      if (error !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL len_over: err=%b rdy=%b need 1/0",
                  error, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      repeat (4) @(negedge clock);
      bus.in_valid = 1'b0;
      checks++;
      if (got_a.size() != 0 || error !== 1'b1 || cpu_hold !== 1'b1) begin
         errors++;
         $display("FAIL len_over_hold: writes=%0d err=%b hold=%b need 0/1/1",
                  got_a.size(), error, cpu_hold);
      end
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h00};
      send_range(0, 3, 0);
      @(negedge clock);
      checks++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || got_a.size() != 0) begin
         errors++;
         $display("FAIL len_zero: done=%b hold=%b writes=%0d need 1/0/0",
                  done, cpu_hold, got_a.size());
      end
   endtask

   task automatic test_max_len();
      pulse_start();
      make_frame(1 << AW, 1'b0);
      model_frame();
      got_a.delete();
      got_d.delete();
      send_range(0, frame.size(), 0);
      checks++;
      if (done !== 1'b1 || exp_res != 1) begin
         errors++;
         $display("FAIL max_len_done: done=%b model=%0d need 1/1",
                  done, exp_res);
      end
      checks++;
      if (got_a.size() != exp_a.size()) begin
         errors++;
         $display("FAIL max_len_count: writes=%0d need %0d",
                  got_a.size(), exp_a.size());
      end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         checks++;
         if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL max_len_wr%0d: %h:%h need %h:%h", i,
                     got_a[i], got_d[i], exp_a[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_random_gaps();
      for (int t = 0; t < 8; t++) begin
         pulse_start();
         if (t == 0)
            fixed_frame(8'h29);
         else
            make_frame($urandom_range(1, 9), $urandom_range(0, 3) == 0);
         model_frame();
         got_a.delete();
         got_d.delete();
         send_range(0, frame.size(), 50);
         @(negedge clock);
         checks++;
         if (done !== (exp_res == 1) || error !== (exp_res == 2) ||
             cpu_hold !== (exp_res != 1)) begin
            errors++;
            $display("FAIL gap%0d_state: done=%b err=%b hold=%b model=%0d",
                     t, done, error, cpu_hold, exp_res);
         end
         checks++;
         if (got_a.size() != exp_a.size()) begin
            errors++;
            $display("FAIL gap%0d_count: writes=%0d need %0d",
                     t, got_a.size(), exp_a.size());
         end
         for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
               errors++;
               $display("FAIL gap%0d_wr%0d: %h:%h need %h:%h", t, i,
                        got_a[i], got_d[i], exp_a[i], exp_d[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      pulse_start();
      make_frame(2, 1'b0);
      send_range(0, 8, 0);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.imem_we, cpu_hold, done, error}
          !== 5'b10100 || bus.imem_addr !== '0 ||
          bus.imem_wdata !== '0) begin
         errors++;
         $display("FAIL mid_reset: flags=%b addr=%h wdata=%h need 10100/0/0",
                  {bus.in_ready, bus.imem_we, cpu_hold, done, error},
                  bus.imem_addr, bus.imem_wdata);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      make_frame(3, 1'b0);
      model_frame();
      got_a.delete();
      got_d.delete();
      send_range(0, frame.size(), 0);
      checks++;
      if (done !== 1'b1 || got_a.size() != 3) begin
         errors++;
         $display("FAIL post_reset: done=%b writes=%0d need 1/3",
                  done, got_a.size());
      end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         checks++;
         if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL post_reset_wr%0d: %h:%h need %h:%h", i,
                     got_a[i], got_d[i], exp_a[i], exp_d[i]);
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_len_limits();
      test_max_len();
      test_random_gaps();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
